fdiv_unit: RTL and testbench
============================

// Module: fdiv_unit
// PURPOSE
//  Multi-cycle IEEE-754 single-precision divider (FDIV.S, funct5 5'b00011): the inverse
//  datapath to the single-cycle FMUL in the FP ALU. It sits beside the FP ALU in EX.
//  The pipeline holds EX stalled while busy=1 and takes out on done.
//  Result conventions match the FP ALU: truncation, no NaN/Inf/denormal support,
//  overflow -> 32'hFFFFFFFF.
// PARAMETERS
//  STEPS_PER_CYCLE  1   restoring-division steps per DIV cycle; legal values 1, 5, 25
//                       (must divide 25)
// PORTS
//  clk       in   1   clock; all state changes on the rising edge
//  rst_n     in   1   synchronous reset, active-low
//  start     in   1   request; sampled only in IDLE
//  flush     in   1   pipeline flush; aborts the operation in flight
//  operand1  in   32  dividend (IEEE single)
//  operand2  in   32  divisor (IEEE single)
//  busy      out  1   high from the cycle after start is accepted until done is pulsed
//  done      out  1   one-cycle pulse; out is valid in the same cycle
//  out       out  32  quotient register; holds its value until the next done
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state=IDLE; busy=0, done=0, out=0. This applies mid-operation too.
//  FSM: IDLE -> PREP -> DIV -> NORM -> DONE -> IDLE.
//  - IDLE: start=1 latches operand1/operand2 and moves to PREP. start in any other state is ignored.
//  - PREP: unpack both operands. An exponent field of 0 means the value is zero; mantissas
//    become {1,man}. Special cases go straight to DONE:
//      divisor zero -> 32'hFFFFFFFF;
//      dividend zero (divisor nonzero) -> {s1^s2, 31'd0}.
//    Otherwise: rem = {1,man1}, div = {1,man2}, and e = e1 - e2 + 127, held as 10-bit signed.
//  - DIV: restoring division, one quotient bit per step, MSB first:
//      if rem >= div: rem = (rem - div) << 1, q bit = 1; else rem <<= 1, q bit = 0.
//    Runs 25 steps in 25/STEPS_PER_CYCLE cycles; step counter 0..24.
//    q[24:0] = floor(m1 * 2^24 / m2).
//  - NORM:
//      q[24]=1 -> man = q[23:1], exp = e;
//      q[24]=0 -> man = q[22:0], exp = e - 1.
//    exp >= 255 -> 32'hFFFFFFFF; exp <= 0 -> {s1^s2, 31'd0};
//    otherwise {s1^s2, exp[7:0], man}. Remainder bits are discarded (truncate).
//  - DONE: out loaded, done=1 for exactly one cycle, busy=0; next state IDLE.
//    A start in the following cycle is accepted.
//  Latency, counting the start-accept edge as cycle 0:
//    normal path: done in cycle 3 + 25/STEPS_PER_CYCLE (28 when STEPS_PER_CYCLE=1);
//    special case: done in cycle 2.
//  busy=1 in PREP, DIV and NORM; busy=0 in IDLE and DONE.
//  flush=1 in any non-IDLE state: return to IDLE at that edge; no done; out unchanged.
//    flush has priority over the normal transition, including PREP->DONE and NORM->DONE.
//  flush and start together in IDLE: flush wins; the request is dropped.
//  rem width is 26 bits, so rem - div never loses a carry.
//  e is computed in 10-bit signed arithmetic, so both extremes fall inside the overflow/zero
//  checks.
// STRUCTURE
//  fp_defs package, shared with the FP ALU:
//    funct5 constants (ADD, SUB, MUL, FDIV=5'b00011, MIN_MAX, FCVT*, FMV*, FEQ_LT_LE);
//    FP_OVF = 32'hFFFFFFFF; EXP_BIAS = 127.
//  FSM state encoding: local enum/localparam inside fdiv_unit.
//  One sub-module, fdiv_step: purely combinational single restoring step
//    inputs rem[25:0], div[23:0]; outputs rem_next, qbit.
//    STEPS_PER_CYCLE copies are chained in a generate loop.
// TESTING
//  1. 0x40C00000 / 0x40000000 (6/2), S=1 -> out=0x40400000; done at cycle 28; busy high cycles 1-27.
//  2. 0x3F800000 / 0x40400000 (1/3) -> out=0x3EAAAAAA (truncated); repeat with S=5 -> done at cycle 8.
//  3. 0xBF800000 / 0x00000000 -> out=0xFFFFFFFF; done at cycle 2.
//     0x00000000 / 0xC0A00000 -> out=0x80000000.
//  4. 0x7F000000 / 0x3E800000 -> exp 256 -> out=0xFFFFFFFF.
//     0x00800000 / 0x7F000000 -> exp <= 0 -> out=0x00000000.
//  5. start, then flush at cycle 10 -> busy=0 at cycle 11, no done pulse, out keeps its old value.
//     Then start 6/2 -> 0x40400000 in 28 cycles.
//  6. start pulsed again while busy -> ignored.
//     rst_n=0 at cycle 15 -> busy=0, done=0, out=0.
//     Back-to-back start the cycle after done -> accepted.

Source files
------------

// File: rtl/fdiv_unit_pkg.sv
// Shared floating-point definitions for the FP ALU and the multi-cycle divider.
package fp_defs;

    // funct5 encodings of the FP operations
    localparam logic [4:0] FUNCT5_ADD       = 5'b00000;
    localparam logic [4:0] FUNCT5_SUB       = 5'b00001;
    localparam logic [4:0] FUNCT5_MUL       = 5'b00010;
    localparam logic [4:0] FUNCT5_FDIV      = 5'b00011;
    localparam logic [4:0] FUNCT5_MIN_MAX   = 5'b00101;
    localparam logic [4:0] FUNCT5_FCVT_W_S  = 5'b11000;
    localparam logic [4:0] FUNCT5_FCVT_S_W  = 5'b11010;
    localparam logic [4:0] FUNCT5_FMV_X_W   = 5'b11100;
    localparam logic [4:0] FUNCT5_FMV_W_X   = 5'b11110;
    localparam logic [4:0] FUNCT5_FEQ_LT_LE = 5'b10100;

    // Overflow result shared by the whole FP datapath
    localparam logic [31:0] FP_OVF = 32'hFFFF_FFFF;

    // Exponent bias, widened to the signed 10-bit exponent arithmetic width
    localparam logic signed [9:0] EXP_BIAS = 10'sd127;

    // Unpacked view of an IEEE single
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    // Denormals are not supported: a zero exponent field means the value is zero
    function automatic logic fp_is_zero(input logic [7:0] exp_field);
        return (exp_field == 8'd0);
    endfunction

    // Assemble a single from its fields
    function automatic logic [31:0] fp_pack(input logic sign, input logic [7:0] exp_field,
                                            input logic [22:0] man);
        return {sign, exp_field, man};
    endfunction

endpackage

// File: rtl/fdiv_step.sv
// One combinational restoring-division step: compare, conditionally subtract, shift.
module fdiv_step (
    input  logic [25:0] rem,
    input  logic [23:0] div,
    output logic [25:0] rem_next,
    output logic        qbit
);

    logic [25:0] w_diff;
    logic [25:0] w_sel;

    assign w_diff = rem - {2'b00, div};

    // Choose restored or reduced remainder and emit the quotient bit
    always_comb begin
        w_sel = rem;
        qbit  = 1'b0;
        if (rem >= {2'b00, div}) begin
            w_sel = w_diff;
            qbit  = 1'b1;
        end else begin
            w_sel = rem;
            qbit  = 1'b0;
        end
    end

    // The remainder stays below 2*div < 2^25, so the shift never drops a set bit
    assign rem_next = w_sel << 1;

endmodule

// File: rtl/fdiv_unit.sv
// Multi-cycle single-precision divider (FDIV.S). Truncating, no NaN/Inf/denormal
// handling, overflow saturates to all-ones like the rest of the FP ALU.
module fdiv_unit
    import fp_defs::*;
#(
    // Restoring steps per DIV cycle; must divide 25 (1, 5 or 25)
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        flush,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    output logic        busy,
    output logic        done,
    output logic [31:0] out
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_DIV  = 3'd2,
        S_NORM = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [4:0] STEP_INC  = 5'(STEPS_PER_CYCLE);
    localparam logic [4:0] LAST_STEP = 5'(25 - STEPS_PER_CYCLE);

    state_t               r_state;
    state_t               w_next;
    logic [31:0]          r_op1;
    logic [31:0]          r_op2;
    logic                 r_sign;
    logic signed [9:0]    r_exp;
    logic [25:0]          r_rem;
    logic [23:0]          r_div;
    logic [24:0]          r_q;
    logic [4:0]           r_cnt;
    logic [31:0]          r_out;
    logic                 r_busy;
    logic                 r_done;

    logic [31:0]          w_result;
    fp32_t                w_f1;
    fp32_t                w_f2;
    logic                 w_zero1;
    logic                 w_zero2;
    logic                 w_sign;
    logic                 w_special;
    logic [31:0]          w_special_res;
    logic signed [9:0]    w_exp_prep;
    logic signed [9:0]    w_exp_norm;
    logic [22:0]          w_man_norm;
    logic [31:0]          w_norm_res;
    logic [25:0]          w_rem_chain [0:STEPS_PER_CYCLE];
    logic [STEPS_PER_CYCLE-1:0] w_qbits;
    logic [24:0]          w_q_next;

    // ---------------- operand unpack (PREP) ----------------
    assign w_f1          = fp32_t'(r_op1);
    assign w_f2          = fp32_t'(r_op2);
    assign w_zero1       = fp_is_zero(w_f1.exp);
    assign w_zero2       = fp_is_zero(w_f2.exp);
    assign w_sign        = w_f1.sign ^ w_f2.sign;
    assign w_special     = w_zero1 | w_zero2;
    // Divide by zero dominates a zero dividend
    assign w_special_res = w_zero2 ? FP_OVF : fp_pack(w_sign, 8'd0, 23'd0);
    // 10-bit signed keeps both extremes (-128 and 382) representable
    assign w_exp_prep    = $signed({2'b00, w_f1.exp}) - $signed({2'b00, w_f2.exp}) + EXP_BIAS;

    // ---------------- restoring division chain (DIV) ----------------
    assign w_rem_chain[0] = r_rem;

    genvar g;
    generate
        for (g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
            fdiv_step u_step (
                .rem      (w_rem_chain[g]),
                .div      (r_div),
                .rem_next (w_rem_chain[g+1]),
                .qbit     (w_qbits[STEPS_PER_CYCLE-1-g])
            );
        end
        if (STEPS_PER_CYCLE == 25) begin : g_q_full
            assign w_q_next = w_qbits;
        end else begin : g_q_shift
            assign w_q_next = {r_q[24-STEPS_PER_CYCLE:0], w_qbits};
        end
    endgenerate

    // ---------------- normalisation (NORM) ----------------
    assign w_exp_norm = r_q[24] ? r_exp : (r_exp - 10'sd1);
    assign w_man_norm = r_q[24] ? r_q[23:1] : r_q[22:0];

    // Saturate on overflow, flush to signed zero on underflow, otherwise pack
    always_comb begin
        w_norm_res = 32'd0;
        if (w_exp_norm >= 10'sd255) begin
            w_norm_res = FP_OVF;
        end else if (w_exp_norm <= 10'sd0) begin
            w_norm_res = fp_pack(r_sign, 8'd0, 23'd0);
        end else begin
            w_norm_res = fp_pack(r_sign, w_exp_norm[7:0], w_man_norm);
        end
    end

    // ---------------- control FSM ----------------
    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and the result to load on entry to DONE; flush beats every transition
    always_comb begin
        w_next   = r_state;
        w_result = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (flush) begin
                    w_next = S_IDLE;
                end else if (start) begin
                    w_next = S_PREP;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_PREP: begin
                if (flush) begin
                    w_next = S_IDLE;
                end else if (w_special) begin
                    w_next   = S_DONE;
                    w_result = w_special_res;
                end else begin
                    w_next = S_DIV;
                end
            end
            S_DIV: begin
                if (flush) begin
                    w_next = S_IDLE;
                end else if (r_cnt == LAST_STEP) begin
                    w_next = S_NORM;
                end else begin
                    w_next = S_DIV;
                end
            end
            S_NORM: begin
                if (flush) begin
                    w_next = S_IDLE;
                end else begin
                    w_next   = S_DONE;
                    w_result = w_norm_res;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ---------------- datapath registers ----------------
    // Operand latch, unpack, and division iteration state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op1  <= 32'd0;
            r_op2  <= 32'd0;
            r_sign <= 1'b0;
            r_exp  <= 10'sd0;
            r_rem  <= 26'd0;
            r_div  <= 24'd0;
            r_q    <= 25'd0;
            r_cnt  <= 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !flush) begin
                        r_op1 <= operand1;
                        r_op2 <= operand2;
                    end
                end
                S_PREP: begin
                    r_sign <= w_sign;
                    r_exp  <= w_exp_prep;
                    r_rem  <= {2'b00, 1'b1, w_f1.man};
                    r_div  <= {1'b1, w_f2.man};
                    r_q    <= 25'd0;
                    r_cnt  <= 5'd0;
                end
                S_DIV: begin
                    r_rem <= w_rem_chain[STEPS_PER_CYCLE];
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + STEP_INC;
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    // Registered handshake outputs and the quotient register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_out  <= 32'd0;
        end else begin
            r_busy <= (w_next == S_PREP) || (w_next == S_DIV) || (w_next == S_NORM);
            r_done <= (w_next == S_DONE);
            if (w_next == S_DONE) begin
                r_out <= w_result;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign out  = r_out;

endmodule

// File: tb/tb_fdiv_unit.sv
// Self-checking bench for fdiv_unit: one instance per step rate, a queue of
// expected quotients filled at start and drained on done.
module tb_fdiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start1;
    logic        start5;
    logic        flush;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        busy1, done1;
    logic [31:0] out1;
    logic        busy5, done5;
    logic [31:0] out5;

    int total;
    int bad;
    logic [31:0] exp_q[$];
    logic [31:0] last_out1;

    fdiv_unit #(.STEPS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .flush(flush),
        .operand1(operand1), .operand2(operand2),
        .busy(busy1), .done(done1), .out(out1)
    );

    fdiv_unit #(.STEPS_PER_CYCLE(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .flush(flush),
        .operand1(operand1), .operand2(operand2),
        .busy(busy5), .done(done5), .out(out5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference quotient from an integer long division of the mantissas
    function automatic logic [31:0] model_div(input logic [31:0] a, input logic [31:0] b);
        logic [23:0] m1, m2;
        logic [63:0] q;
        int e;
        logic s;
        s = a[31] ^ b[31];
        if (b[30:23] == 8'd0) return 32'hFFFF_FFFF;
        if (a[30:23] == 8'd0) return {s, 31'd0};
        m1 = {1'b1, a[22:0]};
        m2 = {1'b1, b[22:0]};
        q  = {16'd0, m1, 24'd0} / {40'd0, m2};
        e  = int'(a[30:23]) - int'(b[30:23]) + 127;
        if (q[24] == 1'b0) e = e - 1;
        if (e >= 255) return 32'hFFFF_FFFF;
        if (e <= 0) return {s, 31'd0};
        if (q[24] == 1'b1) return {s, e[7:0], q[23:1]};
        return {s, e[7:0], q[22:0]};
    endfunction

    // Issue one division and follow it to done; optionally re-pulse start at poke_cyc
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit use5,
                         input int exp_lat, input int poke_cyc);
        int cyc;
        bit seen;
        bit busy_bad;
        logic [31:0] e;
        @(posedge clk); #1;
        @(negedge clk);
        operand1 = a;
        operand2 = b;
        if (use5) start5 = 1'b1; else start1 = 1'b1;
        exp_q.push_back(model_div(a, b));
        @(posedge clk); #1;
        start1 = 1'b0; start5 = 1'b0;
        cyc = 1; seen = 1'b0; busy_bad = 1'b0;
        while (!seen && cyc <= 60) begin
            if (cyc == poke_cyc) begin
                operand1 = 32'h3F80_0000;
                operand2 = 32'h4040_0000;
                if (use5) start5 = 1'b1; else start1 = 1'b1;
            end else begin
                start1 = 1'b0; start5 = 1'b0;
            end
            if ((use5 ? done5 : done1) === 1'b1) begin
                seen = 1'b1;
            end else begin
                if ((use5 ? busy5 : busy1) !== 1'b1) busy_bad = 1'b1;
                @(posedge clk); #1;
                cyc++;
            end
        end
        start1 = 1'b0; start5 = 1'b0;
        e = exp_q.pop_front();
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL done_timeout a=%h b=%h: no done within 60 cycles, required cycle %0d", a, b, exp_lat);
        end else begin
            total++;
            if (cyc !== exp_lat) begin
                bad++;
                $display("FAIL latency a=%h b=%h: got cycle %0d, required %0d", a, b, cyc, exp_lat);
            end
            total++;
            if ((use5 ? out5 : out1) !== e) begin
                bad++;
                $display("FAIL quotient a=%h b=%h: got %h, required %h", a, b, use5 ? out5 : out1, e);
            end
            total++;
            if ((use5 ? busy5 : busy1) !== 1'b0) begin
                bad++;
                $display("FAIL busy_at_done a=%h b=%h: got %b, required 0", a, b, use5 ? busy5 : busy1);
            end
        end
        total++;
        if (busy_bad) begin
            bad++;
            $display("FAIL busy_window a=%h b=%h: busy dropped before done, required 1", a, b);
        end
        if (!use5) last_out1 = e;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy1, done1, out1} !== 34'd0) begin
            bad++;
            $display("FAIL reset_s1: busy=%b done=%b out=%h, required 0/0/00000000", busy1, done1, out1);
        end
        total++;
        if ({busy5, done5, out5} !== 34'd0) begin
            bad++;
            $display("FAIL reset_s5: busy=%b done=%b out=%h, required 0/0/00000000", busy5, done5, out5);
        end
        rst_n = 1'b1;
        last_out1 = 32'd0;
    endtask

    task automatic test_normal();
        do_op(32'h40C0_0000, 32'h4000_0000, 1'b0, 28, 0);
        do_op(32'h3F80_0000, 32'h4040_0000, 1'b0, 28, 0);
        do_op(32'h3F80_0000, 32'h4040_0000, 1'b1, 8, 0);
        do_op(32'hC2F6_E979, 32'h4149_0FDB, 1'b1, 8, 0);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            a[30:23] = 8'($urandom_range(1, 254));
            b[30:23] = 8'($urandom_range(1, 254));
            do_op(a, b, 1'b1, 8, 0);
        end
    endtask

    task automatic test_special();
        do_op(32'hBF80_0000, 32'h0000_0000, 1'b0, 2, 0);
        do_op(32'h0000_0000, 32'hC0A0_0000, 1'b0, 2, 0);
        do_op(32'h0000_0000, 32'h0000_0000, 1'b1, 2, 0);
    endtask

    task automatic test_range();
        do_op(32'h7F00_0000, 32'h3E80_0000, 1'b0, 28, 0);
        do_op(32'h0080_0000, 32'h7F00_0000, 1'b0, 28, 0);
        do_op(32'h3F80_0000, 32'h3F80_0000, 1'b1, 8, 0);
    endtask

    task automatic test_flush();
        int cyc;
        bit stray;
        do_op(32'h3F80_0000, 32'h4040_0000, 1'b0, 28, 0);
        @(posedge clk); #1;
        @(negedge clk);
        operand1 = 32'h40C0_0000; operand2 = 32'h4000_0000; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        cyc = 1;
        while (cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        total++;
        if (busy1 !== 1'b0 || done1 !== 1'b0) begin
            bad++;
            $display("FAIL flush_abort: busy=%b done=%b, required 0/0", busy1, done1);
        end
        total++;
        if (out1 !== last_out1) begin
            bad++;
            $display("FAIL flush_out_hold: got %h, required %h", out1, last_out1);
        end
        stray = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done1 !== 1'b0) stray = 1'b1;
            @(posedge clk); #1;
        end
        total++;
        if (stray) begin
            bad++;
            $display("FAIL flush_no_done: done pulsed after flush, required none");
        end
        // flush together with start in IDLE drops the request
        @(negedge clk);
        start1 = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; flush = 1'b0;
        total++;
        if (busy1 !== 1'b0) begin
            bad++;
            $display("FAIL flush_vs_start: busy=%b, required 0", busy1);
        end
        do_op(32'h40C0_0000, 32'h4000_0000, 1'b0, 28, 0);
    endtask

    task automatic test_busy_ignore_and_reset();
        int cyc;
        // start while busy is ignored: result and latency belong to the first request
        do_op(32'h40C0_0000, 32'h4000_0000, 1'b0, 28, 5);
        @(posedge clk); #1;
        @(negedge clk);
        operand1 = 32'h3F80_0000; operand2 = 32'h4040_0000; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        cyc = 1;
        while (cyc < 15) begin
            @(posedge clk); #1;
            cyc++;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        total++;
        if ({busy1, done1, out1} !== 34'd0) begin
            bad++;
            $display("FAIL reset_mid_op: busy=%b done=%b out=%h, required 0/0/00000000", busy1, done1, out1);
        end
        total++;
        if (out5 !== 32'd0) begin
            bad++;
            $display("FAIL reset_out5: got %h, required 00000000", out5);
        end
        last_out1 = 32'd0;
    endtask

    task automatic test_back_to_back();
        do_op(32'h40C0_0000, 32'h4000_0000, 1'b0, 28, 0);
        // do_op advances one edge (DONE -> IDLE) and raises start in that IDLE cycle
        do_op(32'h3F80_0000, 32'h4040_0000, 1'b0, 28, 0);
        @(posedge clk); #1;
        total++;
        if (done1 !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse_width: done=%b one cycle after pulse, required 0", done1);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        start1 = 1'b0;
        start5 = 1'b0;
        flush = 1'b0;
        operand1 = 32'd0;
        operand2 = 32'd0;
        last_out1 = 32'd0;
        test_reset();
        test_normal();
        test_special();
        test_range();
        test_flush();
        test_busy_ignore_and_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
